// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Covers funct3 width codes, FSM states and the memory request payload.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;
  localparam int unsigned F3_W_BITS = 3;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Word-aligned form of a byte address.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, legality check
// and load extraction/extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3_W_BITS-1:0] funct3,
  input  logic [1:0]           addr_lo,
  input  logic                 we,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [BE_W-1:0]      be_c,
  output logic [XLEN-1:0]      wdata_c,
  output logic                 bad_c,
  output logic [XLEN-1:0]      load_c
);

  logic [XLEN-1:0] lane;

  // Bring the addressed byte/halfword down to bit 0.
  assign lane = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    bad_c   = 1'b0;
    load_c  = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be_c    = BE_W'(4'b0001 << addr_lo);
        wdata_c = {4{wdata[7:0]}};
        bad_c   = we && (funct3 == F3_BU);
        load_c  = (funct3 == F3_B) ? {{24{lane[7]}}, lane[7:0]}
                                   : {24'b0, lane[7:0]};
      end
      F3_H, F3_HU: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
        bad_c   = addr_lo[0] || (we && (funct3 == F3_HU));
        load_c  = (funct3 == F3_H) ? {{16{lane[15]}}, lane[15:0]}
                                   : {16'b0, lane[15:0]};
      end
      F3_W: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        bad_c   = (addr_lo != 2'b00);
        load_c  = mem_rdata;
      end
      default: bad_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns RV32I loads/stores into word-aligned byte-enabled
// req/ack memory transactions, stalling the core until each one completes.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 we_i,
  input  logic [F3_W_BITS-1:0] funct3_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic [XLEN-1:0]      rdata_o,
  output logic                 stall_o,
  output logic                 fault_o,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [BE_W-1:0]      mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ack
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  mem_req_t              req_q;
  logic                  req_on;
  logic [F3_W_BITS-1:0]  f3_q;
  logic [1:0]            lo_q;

  logic [F3_W_BITS-1:0]  sel_f3;
  logic [1:0]            sel_lo;
  logic                  sel_we;
  logic [BE_W-1:0]       be_c;
  logic [XLEN-1:0]       wdata_c;
  logic                  bad_c;
  logic [XLEN-1:0]       load_c;

  // Decode the live instruction in IDLE; use the captured one while waiting for data.
  assign sel_f3 = (state == S_IDLE) ? funct3_i      : f3_q;
  assign sel_lo = (state == S_IDLE) ? addr_i[1:0]   : lo_q;
  assign sel_we = (state == S_IDLE) ? we_i          : req_q.we;

  lsu_align u_align (
    .funct3    (sel_f3),
    .addr_lo   (sel_lo),
    .we        (sel_we),
    .wdata     (wdata_i),
    .mem_rdata (mem_rdata),
    .be_c      (be_c),
    .wdata_c   (wdata_c),
    .bad_c     (bad_c),
    .load_c    (load_c)
  );

  assign stall_o   = ((state == S_IDLE) && valid_i) || (state == S_BUSY);
  assign mem_req   = req_on;
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_be    = req_q.be;
  assign mem_wdata = req_q.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      req_on  <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      rdata_o <= '0;
      fault_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (bad_c) begin
              rdata_o <= '0;
              fault_o <= 1'b1;
              state   <= S_DONE;
            end else begin
              req_q   <= '{we: we_i, addr: word_addr(addr_i), be: be_c, wdata: wdata_c};
              f3_q    <= funct3_i;
              lo_q    <= addr_i[1:0];
              req_on  <= 1'b1;
              cnt     <= '0;
              state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            rdata_o <= req_q.we ? '0 : load_c;
            fault_o <= 1'b0;
            req_on  <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata_o <= '0;
            fault_o <= 1'b1;
            req_on  <= 1'b0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          fault_o <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
